// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display/time-setting controller.
package clock_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    ET_H,
    ET_M,
    ET_S,
    EA_H,
    EA_M
  } state_t;

  localparam logic [3:0] SEP_CODE   = 4'hA;
  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [1:0] FIELD_S = 2'd0;
  localparam logic [1:0] FIELD_M = 2'd1;
  localparam logic [1:0] FIELD_H = 2'd2;

  function automatic logic is_edit(input state_t s);
    return (s != SHOW_TIME) && (s != SHOW_ALARM);
  endfunction

  // Field under edit; the show states default to hours, which is harmless there.
  function automatic logic [1:0] field_of(input state_t s);
    logic [1:0] f;
    f = FIELD_H;
    case (s)
      ET_M, EA_M: f = FIELD_M;
      ET_S:       f = FIELD_S;
      default:    f = FIELD_H;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] disp_word(input logic [23:0] digits);
    return {digits[23:16], SEP_CODE, digits[15:8], SEP_CODE, digits[7:0]};
  endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational BCD increment of one two-digit field, wrapping to 00 past max_value.
module bcd_field_inc (
  input  logic [7:0] value,
  input  logic [7:0] max_value,
  output logic [7:0] result
);

  always_comb begin
    result = 8'h00;
    if (value >= max_value) begin
      result = 8'h00;
    end else if (value[3:0] >= 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/clock_disp_ctrl.sv
// Mode/edit controller: key handling, time load strobe, alarm registers and
// the blinking 8-digit display word for the seven-segment scanner.
module clock_disp_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_MCNT = 12_500_000 - 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        key_inc,
  input  logic [23:0] time_bcd,
  output logic        set_load,
  output logic [23:0] set_value,
  output logic        alarm_en,
  output logic        alarm_hit,
  output logic [31:0] Disp_Data
);

  localparam int CNT_W = (BLINK_MCNT < 1) ? 1 : $clog2(BLINK_MCNT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_MCNT);

  state_t      state, state_nxt;
  logic [23:0] buffer, buffer_nxt;
  logic [15:0] alarm, alarm_nxt;
  logic        alarm_en_nxt;
  logic        load_nxt;
  logic        hit_nxt;
  logic        accepted;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
  logic        blink_on, blink_on_nxt;
  logic [23:0] prev_time;
  logic [1:0]  field_sel;
  logic [7:0]  field_val, field_max, field_inc;
  logic [23:0] digits;
  logic [31:0] disp_nxt;
  logic        act_mode, act_next, act_inc;

  // Only the highest-priority key of a cycle is acted on.
  assign act_mode = key_mode;
  assign act_next = key_next & ~key_mode;
  assign act_inc  = key_inc & ~key_mode & ~key_next;

  always_comb begin
    field_sel = field_of(state);
    field_val = buffer[7:0];
    field_max = MINSEC_MAX;
    case (field_sel)
      FIELD_H: begin
        field_val = buffer[23:16];
        field_max = HOUR_MAX;
      end
      FIELD_M: field_val = buffer[15:8];
      default: field_val = buffer[7:0];
    endcase
  end

  bcd_field_inc u_field_inc (
    .value     (field_val),
    .max_value (field_max),
    .result    (field_inc)
  );

  always_comb begin
    state_nxt    = state;
    buffer_nxt   = buffer;
    alarm_nxt    = alarm;
    alarm_en_nxt = alarm_en;
    load_nxt     = 1'b0;
    accepted     = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (act_mode) begin
          state_nxt = SHOW_ALARM;
          accepted  = 1'b1;
        end else if (act_next) begin
          state_nxt  = ET_H;
          buffer_nxt = time_bcd;
          accepted   = 1'b1;
        end
      end
      SHOW_ALARM: begin
        accepted = act_mode | act_next | act_inc;
        if (act_mode) begin
          state_nxt = SHOW_TIME;
        end else if (act_next) begin
          state_nxt  = EA_H;
          buffer_nxt = {alarm, 8'h00};
        end else if (act_inc) begin
          alarm_en_nxt = ~alarm_en;
        end
      end
      default: begin
        accepted = act_mode | act_next | act_inc;
        if (act_mode) begin
          state_nxt = (state == EA_H || state == EA_M) ? SHOW_ALARM : SHOW_TIME;
        end else if (act_next) begin
          case (state)
            ET_H: state_nxt = ET_M;
            ET_M: state_nxt = ET_S;
            ET_S: begin
              state_nxt = SHOW_TIME;
              load_nxt  = 1'b1;
            end
            EA_H: state_nxt = EA_M;
            default: begin
              state_nxt = SHOW_ALARM;
              alarm_nxt = buffer[23:8];
            end
          endcase
        end else if (act_inc) begin
          case (field_sel)
            FIELD_H: buffer_nxt[23:16] = field_inc;
            FIELD_M: buffer_nxt[15:8]  = field_inc;
            default: buffer_nxt[7:0]   = field_inc;
          endcase
        end
      end
    endcase
  end

  // A key restarts the blink phase so the edited field shows at once.
  always_comb begin
    blink_cnt_nxt = blink_cnt + 1'b1;
    blink_on_nxt  = blink_on;
    if (accepted) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (blink_cnt == CNT_TOP) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = ~blink_on;
    end
  end

  assign hit_nxt = alarm_en && !is_edit(state) && (time_bcd != prev_time) &&
                   (time_bcd == {alarm, 8'h00});

  always_comb begin
    case (state_nxt)
      SHOW_TIME:  digits = time_bcd;
      SHOW_ALARM: digits = {alarm_nxt, 8'h00};
      default:    digits = buffer_nxt;
    endcase
    if (is_edit(state_nxt) && !blink_on_nxt) begin
      case (field_of(state_nxt))
        FIELD_H: digits[23:16] = {SEP_CODE, SEP_CODE};
        FIELD_M: digits[15:8]  = {SEP_CODE, SEP_CODE};
        default: digits[7:0]   = {SEP_CODE, SEP_CODE};
      endcase
    end
    disp_nxt = disp_word(digits);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= SHOW_TIME;
      buffer    <= '0;
      alarm     <= '0;
      alarm_en  <= 1'b0;
      set_load  <= 1'b0;
      set_value <= '0;
      alarm_hit <= 1'b0;
      Disp_Data <= 32'h00A0_0A00;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      prev_time <= '0;
    end else begin
      state     <= state_nxt;
      buffer    <= buffer_nxt;
      alarm     <= alarm_nxt;
      alarm_en  <= alarm_en_nxt;
      set_load  <= load_nxt;
      if (load_nxt) set_value <= buffer;
      alarm_hit <= hit_nxt;
      Disp_Data <= disp_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
      prev_time <= time_bcd;
    end
  end

endmodule

// File: tb/tb_clock_disp_ctrl.sv
// Self-checking bench for clock_disp_ctrl: vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_clock_disp_ctrl;

  localparam int BM = 7;

  logic        clk;
  logic        reset_n;
  logic        key_mode, key_next, key_inc;
  logic [23:0] time_bcd;
  logic        set_load;
  logic [23:0] set_value;
  logic        alarm_en;
  logic        alarm_hit;
  logic [31:0] disp_data;

  int tests_run;
  int tests_failed;

  clock_disp_ctrl #(.BLINK_MCNT(BM)) dut (
    .Clk       (clk),
    .Reset_n   (reset_n),
    .key_mode  (key_mode),
    .key_next  (key_next),
    .key_inc   (key_inc),
    .time_bcd  (time_bcd),
    .set_load  (set_load),
    .set_value (set_value),
    .alarm_en  (alarm_en),
    .alarm_hit (alarm_hit),
    .Disp_Data (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: view (0 time / 1 alarm), edit flag, field 0=h 1=m 2=s, integer fields.
  int          m_view, m_field, m_k;
  bit          m_editing, m_en, m_load, m_hit;
  int          m_bh, m_bm, m_bs, m_ah, m_am;
  logic [23:0] m_value, m_prev;
  logic [31:0] m_disp;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd2(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [23:0] sec_to_bcd(input int s);
    return {bcd2(s / 3600), bcd2((s / 60) % 60), bcd2(s % 60)};
  endfunction

  task automatic model_reset();
    m_view = 0; m_field = 0; m_k = 0; m_editing = 0; m_en = 0; m_load = 0; m_hit = 0;
    m_bh = 0; m_bm = 0; m_bs = 0; m_ah = 0; m_am = 0;
    m_value = '0; m_prev = '0; m_disp = 32'h00A0_0A00;
  endtask

  task automatic model_step(input logic mode, input logic next, input logic inc, input logic [23:0] t);
    bit acc;
    bit blink;
    logic [23:0] digits;
    m_hit  = m_en && !m_editing && (t != m_prev) && (t == {bcd2(m_ah), bcd2(m_am), 8'h00});
    m_prev = t;
    m_load = 0;
    acc    = 0;
    if (mode) begin
      acc = 1;
      if (m_editing) m_editing = 0;
      else m_view = 1 - m_view;
    end else if (next) begin
      acc = 1;
      if (!m_editing) begin
        m_editing = 1;
        m_field = 0;
        if (m_view == 0) begin
          m_bh = from_bcd2(t[23:16]); m_bm = from_bcd2(t[15:8]); m_bs = from_bcd2(t[7:0]);
        end else begin
          m_bh = m_ah; m_bm = m_am; m_bs = 0;
        end
      end else if ((m_view == 0 && m_field == 2) || (m_view == 1 && m_field == 1)) begin
        m_editing = 0;
        if (m_view == 0) begin
          m_load = 1;
          m_value = {bcd2(m_bh), bcd2(m_bm), bcd2(m_bs)};
        end else begin
          m_ah = m_bh; m_am = m_bm;
        end
      end else begin
        m_field++;
      end
    end else if (inc) begin
      if (m_editing) begin
        acc = 1;
        if (m_field == 0) m_bh = (m_bh + 1) % 24;
        else if (m_field == 1) m_bm = (m_bm + 1) % 60;
        else m_bs = (m_bs + 1) % 60;
      end else if (m_view == 1) begin
        acc = 1;
        m_en = !m_en;
      end
    end
    m_k = acc ? 0 : m_k + 1;
    blink = ((m_k / (BM + 1)) % 2) == 0;
    if (m_editing) digits = {bcd2(m_bh), bcd2(m_bm), bcd2(m_bs)};
    else if (m_view == 0) digits = t;
    else digits = {bcd2(m_ah), bcd2(m_am), 8'h00};
    if (m_editing && !blink) begin
      if (m_field == 0) digits[23:16] = 8'hAA;
      else if (m_field == 1) digits[15:8] = 8'hAA;
      else digits[7:0] = 8'hAA;
    end
    m_disp = {digits[23:16], 4'hA, digits[15:8], 4'hA, digits[7:0]};
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " disp"}, disp_data, m_disp);
    check_output({tag, " set_load"}, 32'(set_load), 32'(m_load));
    check_output({tag, " set_value"}, 32'(set_value), 32'(m_value));
    check_output({tag, " alarm_hit"}, 32'(alarm_hit), 32'(m_hit));
    check_output({tag, " alarm_en"}, 32'(alarm_en), 32'(m_en));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " disp"}, disp_data, 32'h00A0_0A00);
    check_output({tag, " set_load"}, 32'(set_load), 32'h0);
    check_output({tag, " set_value"}, 32'(set_value), 32'h0);
    check_output({tag, " alarm_hit"}, 32'(alarm_hit), 32'h0);
    check_output({tag, " alarm_en"}, 32'(alarm_en), 32'h0);
  endtask

  // One clock cycle with the given keys and time; returns #1 after the edge.
  task automatic apply_stimulus(input logic mode, input logic next, input logic inc, input logic [23:0] t);
    key_mode = mode;
    key_next = next;
    key_inc  = inc;
    time_bcd = t;
    @(posedge clk);
    model_step(mode, next, inc, t);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    key_mode = 1'b0;
    key_next = 1'b0;
    key_inc  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic        mode;
    logic        next;
    logic        inc;
    logic [23:0] t;
    logic [31:0] disp;
    logic        load;
    logic [23:0] value;
    logic        en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic md, input logic nx, input logic ic, input logic [23:0] t,
                              input logic [31:0] d, input logic ld, input logic [23:0] v, input logic en);
    vec_t x;
    x.mode = md; x.next = nx; x.inc = ic; x.t = t;
    x.disp = d; x.load = ld; x.value = v; x.en = en;
    return x;
  endfunction

  initial begin
    int cur_sec;
    logic [23:0] t;
    logic md, nx, ic;
    int r;
    tests_run    = 0;
    tests_failed = 0;
    time_bcd     = '0;

    reset_n  = 1'b0;
    key_mode = 1'b0;
    key_next = 1'b0;
    key_inc  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    vecs.push_back(mk(0,0,0,24'h123456,32'h12A3_4A56,0,24'h0,0));
    vecs.push_back(mk(0,0,0,24'h102030,32'h10A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h10A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,0,1,24'h102030,32'h11A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,0,1,24'h102030,32'h12A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,0,1,24'h102030,32'h13A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h13A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h13A2_0A30,0,24'h0,0));
    vecs.push_back(mk(0,0,1,24'h102030,32'h13A2_0A31,0,24'h0,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h10A2_0A30,1,24'h132031,0));
    vecs.push_back(mk(0,0,0,24'h102030,32'h10A2_0A30,0,24'h132031,0));
    vecs.push_back(mk(1,0,1,24'h102030,32'h00A0_0A00,0,24'h132031,0));
    vecs.push_back(mk(1,0,0,24'h102030,32'h10A2_0A30,0,24'h132031,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h10A2_0A30,0,24'h132031,0));
    vecs.push_back(mk(0,1,0,24'h102030,32'h10A2_0A30,0,24'h132031,0));
    vecs.push_back(mk(0,0,1,24'h102030,32'h10A2_1A30,0,24'h132031,0));
    vecs.push_back(mk(1,0,0,24'h102030,32'h10A2_0A30,0,24'h132031,0));
    vecs.push_back(mk(0,0,0,24'h235909,32'h23A5_9A09,0,24'h132031,0));
    vecs.push_back(mk(0,1,0,24'h235909,32'h23A5_9A09,0,24'h132031,0));
    vecs.push_back(mk(0,0,1,24'h235909,32'h00A5_9A09,0,24'h132031,0));
    vecs.push_back(mk(0,1,0,24'h235909,32'h00A5_9A09,0,24'h132031,0));
    vecs.push_back(mk(0,0,1,24'h235909,32'h00A0_0A09,0,24'h132031,0));
    vecs.push_back(mk(0,1,0,24'h235909,32'h00A0_0A09,0,24'h132031,0));
    vecs.push_back(mk(0,0,1,24'h235909,32'h00A0_0A10,0,24'h132031,0));
    vecs.push_back(mk(1,0,0,24'h235909,32'h23A5_9A09,0,24'h132031,0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].mode, vecs[i].next, vecs[i].inc, vecs[i].t);
      check_output($sformatf("vec%0d disp", i), disp_data, vecs[i].disp);
      check_output($sformatf("vec%0d set_load", i), 32'(set_load), 32'(vecs[i].load));
      check_output($sformatf("vec%0d set_value", i), 32'(set_value), 32'(vecs[i].value));
      check_output($sformatf("vec%0d alarm_en", i), 32'(alarm_en), 32'(vecs[i].en));
      check_output($sformatf("vec%0d alarm_hit", i), 32'(alarm_hit), 32'h0);
    end

    // Set alarm 07:30 and arm it.
    t = 24'h235909;
    apply_stimulus(1,0,0,t);
    check_output("alarm view", disp_data, 32'h00A0_0A00);
    apply_stimulus(0,1,0,t);
    repeat (7) apply_stimulus(0,0,1,t);
    check_output("alarm edit hours", disp_data, 32'h07A0_0A00);
    apply_stimulus(0,1,0,t);
    repeat (30) apply_stimulus(0,0,1,t);
    check_output("alarm edit minutes", disp_data, 32'h07A3_0A00);
    apply_stimulus(0,1,0,t);
    check_output("alarm commit disp", disp_data, 32'h07A3_0A00);
    check_output("alarm commit en", 32'(alarm_en), 32'h0);
    apply_stimulus(0,0,1,t);
    check_output("alarm armed", 32'(alarm_en), 32'h1);
    apply_stimulus(1,0,0,t);
    check_output("back to time", disp_data, 32'h23A5_9A09);
    apply_stimulus(0,0,0,24'h072959);
    check_output("pre-alarm hit", 32'(alarm_hit), 32'h0);
    apply_stimulus(0,0,0,24'h073000);
    check_output("alarm hit", 32'(alarm_hit), 32'h1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0,0,0,24'h073000);
      check_output($sformatf("alarm hold %0d", i), 32'(alarm_hit), 32'h0);
    end
    // Re-arming while equality already holds must not fire.
    t = 24'h073000;
    apply_stimulus(1,0,0,t);
    apply_stimulus(0,0,1,t);
    check_output("disarm hit", 32'(alarm_hit), 32'h0);
    apply_stimulus(0,0,1,t);
    apply_stimulus(0,0,0,t);
    check_output("rearm equal hit", 32'(alarm_hit), 32'h0);
    apply_stimulus(0,0,1,t);
    apply_stimulus(1,0,0,t);
    check_output("disarmed en", 32'(alarm_en), 32'h0);
    apply_stimulus(0,0,0,24'h072959);
    apply_stimulus(0,0,0,24'h073000);
    check_output("disarmed hit", 32'(alarm_hit), 32'h0);

    // Blink of the minutes field.
    t = 24'h102030;
    apply_stimulus(0,0,0,t);
    apply_stimulus(0,1,0,t);
    apply_stimulus(0,1,0,t);
    repeat (BM) apply_stimulus(0,0,0,t);
    check_output("blink still on", disp_data, 32'h10A2_0A30);
    apply_stimulus(0,0,0,t);
    check_output("blink dashed", disp_data, 32'h10AA_AA30);
    apply_stimulus(0,0,1,t);
    check_output("blink restored", disp_data, 32'h10A2_1A30);
    apply_stimulus(1,0,0,t);
    check_output("blink abort load", 32'(set_load), 32'h0);

    // Reset in the middle of an edit.
    apply_stimulus(0,1,0,t);
    apply_stimulus(0,0,1,t);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid-edit reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(0,0,0,t);
    check_output("after reset disp", disp_data, 32'h10A2_0A30);
    check_output("after reset load", 32'(set_load), 32'h0);

    // Randomized run against the reference model.
    do_reset();
    cur_sec = $urandom_range(0, 86399);
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 31);
      md = (r == 0) || (r == 1);
      nx = (r >= 2 && r <= 5) || (r == 1);
      ic = (r >= 6 && r <= 12) || (r == 1);
      r = $urandom_range(0, 15);
      if (r == 0) cur_sec = (m_ah * 3600 + m_am * 60 + 86399) % 86400;
      else if (r == 1) cur_sec = m_ah * 3600 + m_am * 60;
      else if (r <= 5) cur_sec = (cur_sec + 1) % 86400;
      else if (r == 6) cur_sec = $urandom_range(0, 86399);
      apply_stimulus(md, nx, ic, sec_to_bcd(cur_sec));
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
